// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (IDLE / WAIT / DROP)
//   fetch_entry_t : one buffered instruction, {pc, instr}
//   FETCH_DEPTH   : instruction buffer depth
//   PC_STEP       : byte increment between sequential instructions
//   RESET_PC      : fetch address after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [1:0]  FETCH_DEPTH = 2'd2;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bundle of the fetch unit's redirect, memory and
// decode-side signals.
//   redirect_valid/redirect_pc : new fetch target from the branch unit
//   mem_req/mem_addr           : read request to instruction memory
//   mem_ack/mem_rdata          : read completion and data
//   inst_valid/inst_data/inst_pc/inst_ready : decode handshake
// master = the fetch unit, slave = its environment.
interface instr_fetch_unit_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} buffer between memory and decode.
//   clock, reset : clock and synchronous active-high reset
//   push, din    : write one entry
//   pop          : discard the head entry
//   flush        : empty the buffer (wins over push/pop)
//   head         : oldest entry (entry 0), registered
//   count        : number of valid entries, 0..2
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic         do_push;
  logic         do_pop;

  // A push into a full buffer is only legal when a pop frees a slot.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count < FETCH_DEPTH) || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // count stays put; new data lands behind whatever survives the pop
          if (count == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetcher with redirect support
// and a 2-entry instruction buffer.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : redirect input, instruction-memory request/ack, decode handshake
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding; issue when buffer has room
// WAIT  | request at req_pc outstanding; ack data will be buffered
// DROP  | request outstanding but made stale by a redirect; ack dropped
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  logic [31:0]  req_pc, req_pc_nxt;
  logic         push, pop, flush;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t din;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    push         = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.redirect_valid && (count < FETCH_DEPTH)) begin
          state_nxt  = WAIT;
          req_pc_nxt = fetch_pc;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
          if (!bus.redirect_valid) begin
            push         = 1'b1;
            fetch_pc_nxt = req_pc + PC_STEP;
          end
        end else if (bus.redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // The stale request must still complete before a new one is issued.
        if (bus.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.redirect_valid) fetch_pc_nxt = word_align(bus.redirect_pc);
  end

  assign flush = bus.redirect_valid;
  assign pop   = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  assign din   = '{pc: req_pc, instr: bus.mem_rdata};

  fetch_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign bus.mem_req    = (state != IDLE);
  assign bus.mem_addr   = req_pc;
  assign bus.inst_valid = (count != 2'd0);
  assign bus.inst_data  = head.instr;
  assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic clock = 1'b0;
  logic reset;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic        chkd;
    logic [31:0] ipc;
    logic [31:0] idata;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  vec_t        vecs[$];
  exp_t        exp_q[$];
  logic [31:0] exp_addr;
  int          wcnt;
  int          got;
  int          first_valid;

  function automatic vec_t v(input logic rst, input logic rv, input logic [31:0] rpc,
                             input logic ack, input logic [31:0] rdata, input logic rdy,
                             input logic chk, input logic req, input logic [31:0] addr,
                             input logic iv, input logic chkd, input logic [31:0] ipc,
                             input logic [31:0] idata);
    vec_t r;
    r.rst = rst; r.rv = rv; r.rpc = rpc; r.ack = ack; r.rdata = rdata; r.rdy = rdy;
    r.chk = chk; r.req = req; r.addr = addr; r.iv = iv; r.chkd = chkd;
    r.ipc = ipc; r.idata = idata;
    return r;
  endfunction

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h5A00_0000 ^ {a[15:0], 16'h0000};
  endfunction

  // Memory model: acks one cycle after it first sees mem_req and queues
  // the instruction the decode side should later receive.
  task automatic mem_step();
    if (ifc.mem_ack) begin
      ifc.mem_ack = 1'b0;
    end else if (ifc.mem_req) begin
      if (wcnt == 1) begin
        tests++;
        if (ifc.mem_addr !== exp_addr) begin
          fails++;
          $display("FAIL mem_addr: got %h expected %h", ifc.mem_addr, exp_addr);
        end
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = memfn(exp_addr);
        exp_q.push_back('{pc: exp_addr, data: memfn(exp_addr)});
        exp_addr += 32'd4;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (ifc.inst_valid && ifc.inst_ready) begin
      tests++;
      got++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc %h data %h, expected no transfer",
                 ifc.inst_pc, ifc.inst_data);
      end else begin
        e = exp_q.pop_front();
        if (ifc.inst_pc !== e.pc || ifc.inst_data !== e.data) begin
          fails++;
          $display("FAIL sb_inst: got pc %h data %h, expected pc %h data %h",
                   ifc.inst_pc, ifc.inst_data, e.pc, e.data);
        end
      end
    end
  endtask

  task automatic stream(input int n, input bit rand_ready, input int budget);
    reset              = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.mem_ack        = 1'b0;
    ifc.mem_rdata      = '0;
    ifc.inst_ready     = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_addr    = 32'h0;
    wcnt        = 0;
    got         = 0;
    first_valid = -1;
    for (int k = 0; k < budget && got < n; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      mem_step();
      ifc.inst_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (ifc.inst_valid && first_valid < 0) first_valid = k;
      monitor();
    end
    tests++;
    if (got < n) begin
      fails++;
      $display("FAIL stream_timeout: got %0d transfers, expected %0d", got, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming, decode always ready.
    stream(8, 1'b0, 100);
    tests++;
    if (first_valid != 3) begin
      fails++;
      $display("FAIL first_valid_latency: got %0d expected 3", first_valid);
    end
    // Streaming with random decode backpressure.
    stream(12, 1'b1, 400);

    // rst rv rpc ack rdata rdy | chk req addr iv | chkd ipc idata
    // Backpressure saturates the buffer, drain in order, resume at 8.
    vecs.push_back(v(1,0,0,0,0,0, 0,0,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,0,0, 1,0,0));
    vecs.push_back(v(0,0,0,1,32'hA0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,0,1, 1,0,32'hA0));
    vecs.push_back(v(0,0,0,1,32'hA1,0, 1,1,4,1, 1,0,32'hA0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,4,1, 1,0,32'hA0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,4,1, 1,0,32'hA0));
    vecs.push_back(v(0,0,0,0,0,1, 1,0,4,1, 1,0,32'hA0));
    vecs.push_back(v(0,0,0,0,0,1, 1,0,4,1, 1,4,32'hA1));
    vecs.push_back(v(0,0,0,0,0,1, 1,1,8,0, 0,0,0));
    // Redirect while WAIT at 4, ack two cycles later is dropped.
    vecs.push_back(v(1,0,0,0,0,1, 0,0,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,0,0, 1,0,0));
    vecs.push_back(v(0,0,0,1,32'hB0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,1, 1,0,0,1, 1,0,32'hB0));
    vecs.push_back(v(0,1,32'h103,0,0,1, 1,1,4,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,1,4,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,32'hDEADBEEF,0, 1,1,4,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,4,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,32'hC0,0, 1,1,32'h100,0, 0,0,0));
    // Redirect coinciding with ack and pop while count=1.
    vecs.push_back(v(0,0,0,0,0,0, 1,0,32'h100,1, 1,32'h100,32'hC0));
    vecs.push_back(v(0,1,32'h200,1,32'hC1,1, 1,1,32'h104,1, 1,32'h100,32'hC0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,32'h104,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,32'hC2,0, 1,1,32'h200,0, 0,0,0));
    // Redirect to the top word, then wrap to 0.
    vecs.push_back(v(0,1,32'hFFFF_FFFC,0,0,0, 1,0,32'h200,1, 1,32'h200,32'hC2));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,32'h200,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,32'hE0,0, 1,1,32'hFFFF_FFFC,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,32'hFFFF_FFFC,1, 1,32'hFFFF_FFFC,32'hE0));
    vecs.push_back(v(0,0,0,1,32'hE1,0, 1,1,0,1, 1,32'hFFFF_FFFC,32'hE0));
    // Reset with a full buffer, then reset in DROP and a late ack.
    vecs.push_back(v(1,0,0,0,0,0, 1,0,0,1, 1,32'hFFFF_FFFC,32'hE0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,0,0, 1,0,0));
    vecs.push_back(v(0,1,32'h40,0,0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,32'hBAD0_BAD0,0, 1,0,0,0, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,32'hF0,0, 1,1,0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 1,0,0,1, 1,0,32'hF0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      reset              = vecs[i].rst;
      ifc.redirect_valid = vecs[i].rv;
      ifc.redirect_pc    = vecs[i].rpc;
      ifc.mem_ack        = vecs[i].ack;
      ifc.mem_rdata      = vecs[i].rdata;
      ifc.inst_ready     = vecs[i].rdy;
      @(negedge clock);
      if (vecs[i].chk) begin
        tests++;
        if (ifc.mem_req !== vecs[i].req || ifc.mem_addr !== vecs[i].addr ||
            ifc.inst_valid !== vecs[i].iv ||
            (vecs[i].chkd && (ifc.inst_pc !== vecs[i].ipc || ifc.inst_data !== vecs[i].idata))) begin
          fails++;
          $display("FAIL vec%0d: got req %b addr %h iv %b pc %h data %h; expected req %b addr %h iv %b pc %h data %h (pc/data checked=%b)",
                   i, ifc.mem_req, ifc.mem_addr, ifc.inst_valid, ifc.inst_pc, ifc.inst_data,
                   vecs[i].req, vecs[i].addr, vecs[i].iv, vecs[i].ipc, vecs[i].idata, vecs[i].chkd);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
